// File: rtl/adc_meas_filter.sv
// adc_meas_filter
//   Consumes channel-tagged AD7324 sample words. It checks the channel order,
//   block-averages each of the four channels, and debounces the Vout and Iout
//   samples into latched over-voltage and over-current faults.
//
// Sequencer states
//   state     | meaning
//   ----------+---------------------------------------------------------
//   WAIT_SYNC | samples are discarded until a chID 0 word arrives
//   RUN       | samples are accepted while chID matches the expected channel
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   sample_valid  strobe: sample_word is valid (always accepted)
//   sample_word   [14:13] chID, [12:0] signed code, [15] ignored
//   fault_clr     clears both fault flags and their debounce counters
//   vout_avg, temp_avg, vin_avg, iout_avg   signed block averages
//   avg_valid     per-channel pulse: that average was updated this cycle
//   ov_fault      latched over-voltage fault (Vout)
//   oc_fault      latched over-current fault (Iout)
//   seq_err       one-cycle pulse after an out-of-order chID
module adc_meas_filter #(
    parameter int                 AVG_LOG2  = 3,
    parameter logic signed [12:0] OV_LIMIT  = 13'sd3500,
    parameter logic signed [12:0] OC_LIMIT  = 13'sd3000,
    parameter int                 FAULT_CNT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [15:0]        sample_word,
    input  logic               fault_clr,
    output logic signed [12:0] vout_avg,
    output logic signed [12:0] temp_avg,
    output logic signed [12:0] vin_avg,
    output logic signed [12:0] iout_avg,
    output logic [3:0]         avg_valid,
    output logic               ov_fault,
    output logic               oc_fault,
    output logic               seq_err
);

    localparam int AW = 13 + AVG_LOG2;
    localparam int FW = $clog2(FAULT_CNT + 1);
    localparam logic [FW-1:0] FMAX = FW'(FAULT_CNT);

    typedef enum logic {WAIT_SYNC, RUN} state_t;

    state_t             state, state_nxt;
    logic [1:0]         expected, expected_nxt;
    logic               accept, seq_err_nxt;
    logic [1:0]         ch;
    logic signed [12:0] code;
    logic               unused_msb;

    assign ch         = sample_word[14:13];
    assign code       = sample_word[12:0];
    assign unused_msb = sample_word[15];

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_SYNC;
            expected <= 2'd0;
            seq_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            expected <= expected_nxt;
            seq_err  <= seq_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        accept       = 1'b0;
        seq_err_nxt  = 1'b0;
        if (sample_valid) begin
            case (state)
                WAIT_SYNC: begin
                    if (ch == 2'd0) begin
                        accept       = 1'b1;
                        expected_nxt = 2'd1;
                        state_nxt    = RUN;
                    end
                end
                RUN: begin
                    if (ch == expected) begin
                        accept       = 1'b1;
                        expected_nxt = expected + 2'd1;
                    end else begin
                        seq_err_nxt = 1'b1;
                        state_nxt   = WAIT_SYNC;
                    end
                end
                default: state_nxt = WAIT_SYNC;
            endcase
        end
    end

    // ---------------- block averaging ----------------
    logic signed [AW-1:0]  acc [4];
    logic [AVG_LOG2-1:0]   cnt [4];
    logic signed [12:0]    avg [4];
    logic signed [AW-1:0]  sum, sum_shr;

    assign sum     = acc[ch] + AW'(code);
    assign sum_shr = sum >>> AVG_LOG2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
                avg[i] <= '0;
            end
            avg_valid <= '0;
        end else begin
            avg_valid <= '0;
            if (seq_err_nxt) begin
                // an order break invalidates every partial block
                for (int i = 0; i < 4; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else if (accept) begin
                cnt[ch] <= cnt[ch] + 1'b1;
                if (&cnt[ch]) begin
                    avg[ch]       <= sum_shr[12:0];
                    acc[ch]       <= '0;
                    avg_valid[ch] <= 1'b1;
                end else begin
                    acc[ch] <= sum;
                end
            end
        end
    end

    assign vout_avg = avg[0];
    assign temp_avg = avg[1];
    assign vin_avg  = avg[2];
    assign iout_avg = avg[3];

    // ---------------- fault debounce ----------------
    function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] c);
        return (c == FMAX) ? c : c + 1'b1;
    endfunction

    logic          ov_hit, oc_hit, ov_over, oc_over, ov_trip, oc_trip;
    logic [FW-1:0] ov_cnt, oc_cnt, ov_cnt_nxt, oc_cnt_nxt;

    always_comb begin
        ov_hit     = accept && (ch == 2'd0);
        oc_hit     = accept && (ch == 2'd3);
        ov_over    = ov_hit && (code > OV_LIMIT);
        oc_over    = oc_hit && (code > OC_LIMIT);
        ov_cnt_nxt = ov_cnt;
        oc_cnt_nxt = oc_cnt;
        if (ov_hit) ov_cnt_nxt = ov_over ? sat_inc(ov_cnt) : '0;
        if (oc_hit) oc_cnt_nxt = oc_over ? sat_inc(oc_cnt) : '0;
        ov_trip    = ov_over && (ov_cnt_nxt == FMAX);
        oc_trip    = oc_over && (oc_cnt_nxt == FMAX);
    end

    // a tripping sample beats a simultaneous fault_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_cnt   <= '0;
            oc_cnt   <= '0;
            ov_fault <= 1'b0;
            oc_fault <= 1'b0;
        end else begin
            if (ov_trip) begin
                ov_fault <= 1'b1;
                ov_cnt   <= ov_cnt_nxt;
            end else if (fault_clr) begin
                ov_fault <= 1'b0;
                ov_cnt   <= '0;
            end else begin
                ov_cnt   <= ov_cnt_nxt;
            end

            if (oc_trip) begin
                oc_fault <= 1'b1;
                oc_cnt   <= oc_cnt_nxt;
            end else if (fault_clr) begin
                oc_fault <= 1'b0;
                oc_cnt   <= '0;
            end else begin
                oc_cnt   <= oc_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_adc_meas_filter.sv
module tb_adc_meas_filter;

    localparam int N    = 8;
    localparam int FC   = 3;
    localparam int OVL  = 3500;
    localparam int OCL  = 3000;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_valid;
    logic [15:0]        sample_word;
    logic               fault_clr;
    logic signed [12:0] vout_avg, temp_avg, vin_avg, iout_avg;
    logic [3:0]         avg_valid;
    logic               ov_fault, oc_fault, seq_err;

    int checks = 0;
    int errors = 0;

    adc_meas_filter dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_word(sample_word),
        .fault_clr(fault_clr), .vout_avg(vout_avg), .temp_avg(temp_avg),
        .vin_avg(vin_avg), .iout_avg(iout_avg), .avg_valid(avg_valid),
        .ov_fault(ov_fault), .oc_fault(oc_fault), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       q [4][$];
    bit       synced = 0;
    int       expct = 0;
    int       m_avg [4] = '{0, 0, 0, 0};
    bit [3:0] m_av = '0;
    bit       m_seq = 0, m_ov = 0, m_oc = 0;
    int       ov_run = 0, oc_run = 0;

    function automatic int floor_div(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit acc_s, ov_t, oc_t;
        int c, v, s;
        if (rst) begin
            synced = 0; expct = 0; m_av = '0; m_seq = 0;
            m_ov = 0; m_oc = 0; ov_run = 0; oc_run = 0;
            for (int i = 0; i < 4; i++) begin
                q[i].delete();
                m_avg[i] = 0;
            end
        end else begin
            m_av = '0; m_seq = 0; acc_s = 0; ov_t = 0; oc_t = 0;
            c = int'(sample_word[14:13]);
            v = int'($signed(sample_word[12:0]));
            if (sample_valid) begin
                if (!synced) begin
                    if (c == 0) begin synced = 1; expct = 1; acc_s = 1; end
                end else if (c == expct) begin
                    acc_s = 1; expct = (expct + 1) % 4;
                end else begin
                    m_seq = 1; synced = 0;
                    for (int i = 0; i < 4; i++) q[i].delete();
                end
            end
            if (acc_s) begin
                q[c].push_back(v);
                if (q[c].size() == N) begin
                    s = 0;
                    foreach (q[c][k]) s += q[c][k];
                    m_avg[c] = floor_div(s, N);
                    m_av[c] = 1'b1;
                    q[c].delete();
                end
                if (c == 0) begin
                    ov_run = (v > OVL) ? ((ov_run < FC) ? ov_run + 1 : FC) : 0;
                    ov_t = (v > OVL) && (ov_run == FC);
                end
                if (c == 3) begin
                    oc_run = (v > OCL) ? ((oc_run < FC) ? oc_run + 1 : FC) : 0;
                    oc_t = (v > OCL) && (oc_run == FC);
                end
            end
            if (ov_t) m_ov = 1;
            else if (fault_clr) begin m_ov = 0; ov_run = 0; end
            if (oc_t) m_oc = 1;
            else if (fault_clr) begin m_oc = 0; oc_run = 0; end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("vout_avg",  int'(vout_avg),  m_avg[0]);
        check("temp_avg",  int'(temp_avg),  m_avg[1]);
        check("vin_avg",   int'(vin_avg),   m_avg[2]);
        check("iout_avg",  int'(iout_avg),  m_avg[3]);
        check("avg_valid", int'(avg_valid), int'(m_av));
        check("ov_fault",  int'(ov_fault),  int'(m_ov));
        check("oc_fault",  int'(oc_fault),  int'(m_oc));
        check("seq_err",   int'(seq_err),   int'(m_seq));
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input int ch, input int code, input bit clr = 1'b0);
        sample_valid = 1'b1;
        sample_word  = {1'b0, 2'(ch), 13'(code)};
        fault_clr    = clr;
        @(negedge clk); #1;
        sample_valid = 1'b0;
        fault_clr    = 1'b0;
    endtask

    task automatic round(input int a, input int b, input int c, input int d);
        send(0, a); send(1, b); send(2, c); send(3, d);
    endtask

    task automatic idle(input bit clr);
        fault_clr = clr;
        @(negedge clk); #1;
        fault_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vout"}, int'(vout_avg), 0);
        check({tag, "_temp"}, int'(temp_avg), 0);
        check({tag, "_vin"},  int'(vin_avg),  0);
        check({tag, "_iout"}, int'(iout_avg), 0);
        check({tag, "_av"},   int'(avg_valid), 0);
        check({tag, "_ov"},   int'(ov_fault), 0);
        check({tag, "_oc"},   int'(oc_fault), 0);
        check({tag, "_seq"},  int'(seq_err),  0);
    endtask

    initial begin
        int vseq [6] = '{3501, 3501, 3500, 3501, 3501, 3501};
        int first;
        rst = 1'b1; sample_valid = 1'b0; sample_word = '0; fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // basic averaging
        repeat (7) round(100, 200, 300, 400);
        send(0, 100); check("av_ch0", int'(avg_valid), 1);
        send(1, 200); check("av_ch1", int'(avg_valid), 2);
        send(2, 300); check("av_ch2", int'(avg_valid), 4);
        send(3, 400); check("av_ch3", int'(avg_valid), 8);
        check("avg100", int'(vout_avg), 100);
        check("avg200", int'(temp_avg), 200);
        check("avg300", int'(vin_avg),  300);
        check("avg400", int'(iout_avg), 400);

        // rounding toward -inf
        repeat (4) round(0, -1, 0, 0);
        repeat (4) round(0, 0, 0, 0);
        check("temp_floor", int'(temp_avg), -1);

        // most negative code, no wrap
        repeat (8) round(0, -4096, 0, 0);
        check("temp_min", int'(temp_avg), -4096);

        // sequence error clears partials
        send(0, 800); send(1, 0); send(3, 0);
        check("seq_err_pulse", int'(seq_err), 1);
        first = -1;
        for (int k = 0; k < 29; k++) begin
            send(k % 4, (k % 4 == 0) ? 8 : 0);
            if (avg_valid != 4'd0 && first < 0) first = k;
        end
        check("first_av_idx", first, 28);
        check("resync_av", int'(avg_valid), 1);
        check("resync_vout", int'(vout_avg), 8);
        send(1, 0); send(2, 0); send(3, 0);

        // over-voltage debounce
        for (int i = 0; i < 6; i++) begin
            send(0, vseq[i]);
            if (i == 4) check("ov_not_yet", int'(ov_fault), 0);
            if (i == 5) check("ov_set", int'(ov_fault), 1);
            send(1, 0); send(2, 0); send(3, 0);
        end
        idle(1'b1);
        check("ov_clr", int'(ov_fault), 0);

        // over-current debounce and clear priority
        repeat (3) round(0, 0, 0, 3001);
        check("oc_set", int'(oc_fault), 1);
        idle(1'b1);
        check("oc_clr", int'(oc_fault), 0);
        repeat (2) round(0, 0, 0, 3001);
        send(0, 0); send(1, 0); send(2, 0); send(3, 3001, 1'b1);
        check("oc_set_wins", int'(oc_fault), 1);

        // async reset mid-average
        repeat (5) round(50, 60, 70, 80);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk); #1;
        rst = 1'b0;

        // stream starting at ch2 is discarded until ch0
        send(2, 5); send(3, 5); send(1, 5);
        repeat (8) round(16, 32, 48, 64);
        check("sync_av", int'(avg_valid), 8);
        check("sync_vout", int'(vout_avg), 16);
        check("sync_vin",  int'(vin_avg),  48);
        check("sync_iout", int'(iout_avg), 64);

        repeat (3) idle(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
